// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, immediate select,
// load-use hazard detection with bubble insertion, and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic              ALUSrc_i,
  input  logic [CTRL_W-1:0] ALUCtrl_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              EXMEM_RegWrite_i,
  input  logic [REG_AW-1:0] EXMEM_RDaddr_i,
  input  logic [DATA_W-1:0] EXMEM_data_i,
  input  logic              MEMWB_RegWrite_i,
  input  logic [REG_AW-1:0] MEMWB_RDaddr_i,
  input  logic [DATA_W-1:0] MEMWB_data_i,
  output logic              hazard_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              valid_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs1_data_q;
  logic [DATA_W-1:0] rs2_data_q;
  logic [DATA_W-1:0] imm_q;
  logic              alu_src_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              reg_write_q;
  logic              memto_reg_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  logic              fwd_a_ex;
  logic              fwd_a_wb;
  logic              fwd_b_ex;
  logic              fwd_b_wb;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // A load in EX whose destination is read by the instruction in ID cannot forward in time
  assign hazard_o = valid_q & mem_read_q & (rd_q != '0) & valid_i &
                    ((rd_q == RS1addr_i) | (rd_q == RS2addr_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= '0;
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!stall_i) begin
      if (flush_i || hazard_o) begin
        valid_q     <= 1'b0;
        rs1_q       <= '0;
        rs2_q       <= '0;
        rd_q        <= '0;
        rs1_data_q  <= '0;
        rs2_data_q  <= '0;
        imm_q       <= '0;
        alu_src_q   <= 1'b0;
        alu_ctrl_q  <= '0;
        reg_write_q <= 1'b0;
        memto_reg_q <= 1'b0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end else begin
        // An empty ID slot still latches its fields but must not cause side effects
        valid_q     <= valid_i;
        rs1_q       <= RS1addr_i;
        rs2_q       <= RS2addr_i;
        rd_q        <= RDaddr_i;
        rs1_data_q  <= RS1data_i;
        rs2_data_q  <= RS2data_i;
        imm_q       <= Imm_i;
        alu_src_q   <= ALUSrc_i;
        alu_ctrl_q  <= ALUCtrl_i;
        reg_write_q <= RegWrite_i & valid_i;
        memto_reg_q <= MemtoReg_i & valid_i;
        mem_read_q  <= MemRead_i & valid_i;
        mem_write_q <= MemWrite_i & valid_i;
      end
    end
  end

  // Only hazard bubbles are counted; flushes are a branch cost, not a load-use cost
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else if (!stall_i && !flush_i && hazard_o && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign fwd_a_ex = EXMEM_RegWrite_i & (EXMEM_RDaddr_i != '0) & (EXMEM_RDaddr_i == rs1_q);
  assign fwd_a_wb = MEMWB_RegWrite_i & (MEMWB_RDaddr_i != '0) & (MEMWB_RDaddr_i == rs1_q);
  assign fwd_b_ex = EXMEM_RegWrite_i & (EXMEM_RDaddr_i != '0) & (EXMEM_RDaddr_i == rs2_q);
  assign fwd_b_wb = MEMWB_RegWrite_i & (MEMWB_RDaddr_i != '0) & (MEMWB_RDaddr_i == rs2_q);

  // EX/MEM holds the younger result, so it wins when both stages match
  always_comb begin
    fwd_a = rs1_data_q;
    if (fwd_a_ex) begin
      fwd_a = EXMEM_data_i;
    end else if (fwd_a_wb) begin
      fwd_a = MEMWB_data_i;
    end
  end

  always_comb begin
    fwd_b = rs2_data_q;
    if (fwd_b_ex) begin
      fwd_b = EXMEM_data_i;
    end else if (fwd_b_wb) begin
      fwd_b = MEMWB_data_i;
    end
  end

  assign data1_o      = fwd_a;
  assign data2_o      = alu_src_q ? imm_q : fwd_b;
  assign RS2data_o    = fwd_b;
  assign valid_o      = valid_q;
  assign ALUCtrl_o    = alu_ctrl_q;
  assign RDaddr_o     = rd_q;
  assign RegWrite_o   = reg_write_q;
  assign MemtoReg_o   = memto_reg_q;
  assign MemRead_o    = mem_read_q;
  assign MemWrite_o   = mem_write_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for load/forwarding plus sequences for
// load-use bubbles, stall/flush priority, mid-cycle reset and counter saturation.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 3;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              stall_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              valid_i = 1'b0;
  logic [REG_AW-1:0] RS1addr_i = '0;
  logic [REG_AW-1:0] RS2addr_i = '0;
  logic [REG_AW-1:0] RDaddr_i = '0;
  logic [DATA_W-1:0] RS1data_i = '0;
  logic [DATA_W-1:0] RS2data_i = '0;
  logic [DATA_W-1:0] Imm_i = '0;
  logic              ALUSrc_i = 1'b0;
  logic [CTRL_W-1:0] ALUCtrl_i = '0;
  logic              RegWrite_i = 1'b0;
  logic              MemtoReg_i = 1'b0;
  logic              MemRead_i = 1'b0;
  logic              MemWrite_i = 1'b0;
  logic              EXMEM_RegWrite_i = 1'b0;
  logic [REG_AW-1:0] EXMEM_RDaddr_i = '0;
  logic [DATA_W-1:0] EXMEM_data_i = '0;
  logic              MEMWB_RegWrite_i = 1'b0;
  logic [REG_AW-1:0] MEMWB_RDaddr_i = '0;
  logic [DATA_W-1:0] MEMWB_data_i = '0;

  logic              hazard_o, valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
  logic [DATA_W-1:0] data1_o, data2_o, RS2data_o;
  logic [CTRL_W-1:0] ALUCtrl_o;
  logic [REG_AW-1:0] RDaddr_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  logic              s_hazard, s_valid, s_rw, s_mtr, s_mr, s_mw;
  logic [DATA_W-1:0] s_data1, s_data2, s_rs2data;
  logic [CTRL_W-1:0] s_ctrl;
  logic [REG_AW-1:0] s_rd;
  logic [SAT_W-1:0]  s_cnt;

  int num_checks = 0;
  int num_fail = 0;

  typedef struct {
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [DATA_W-1:0] d1, d2, imm;
    logic              alu_src;
    logic [CTRL_W-1:0] ctrl;
    logic              rw, mtr, mr, mw, vld;
    logic              ex_we;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_data;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              e_vld;
    logic [DATA_W-1:0] e_d1, e_d2, e_rs2d;
    logic [CTRL_W-1:0] e_ctrl;
    logic [REG_AW-1:0] e_rd;
    logic              e_rw, e_mtr, e_mr, e_mw;
  } vec_t;

  vec_t vecs[10];

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .ALUSrc_i(ALUSrc_i),
    .ALUCtrl_i(ALUCtrl_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_RDaddr_i(EXMEM_RDaddr_i),
    .EXMEM_data_i(EXMEM_data_i), .MEMWB_RegWrite_i(MEMWB_RegWrite_i),
    .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_data_i(MEMWB_data_i),
    .hazard_o(hazard_o), .valid_o(valid_o), .data1_o(data1_o), .data2_o(data2_o),
    .ALUCtrl_o(ALUCtrl_o), .RS2data_o(RS2data_o), .RDaddr_o(RDaddr_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // Narrow-counter twin sharing all inputs so saturation is reachable in a few cycles
  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(SAT_W)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .ALUSrc_i(ALUSrc_i),
    .ALUCtrl_i(ALUCtrl_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_RDaddr_i(EXMEM_RDaddr_i),
    .EXMEM_data_i(EXMEM_data_i), .MEMWB_RegWrite_i(MEMWB_RegWrite_i),
    .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_data_i(MEMWB_data_i),
    .hazard_o(s_hazard), .valid_o(s_valid), .data1_o(s_data1), .data2_o(s_data2),
    .ALUCtrl_o(s_ctrl), .RS2data_o(s_rs2data), .RDaddr_o(s_rd),
    .RegWrite_o(s_rw), .MemtoReg_o(s_mtr), .MemRead_o(s_mr),
    .MemWrite_o(s_mw), .bubble_cnt_o(s_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    RS1addr_i = v.rs1;  RS2addr_i = v.rs2;  RDaddr_i = v.rd;
    RS1data_i = v.d1;   RS2data_i = v.d2;   Imm_i = v.imm;
    ALUSrc_i = v.alu_src; ALUCtrl_i = v.ctrl;
    RegWrite_i = v.rw;  MemtoReg_i = v.mtr; MemRead_i = v.mr; MemWrite_i = v.mw;
    valid_i = v.vld;
    EXMEM_RegWrite_i = v.ex_we; EXMEM_RDaddr_i = v.ex_rd; EXMEM_data_i = v.ex_data;
    MEMWB_RegWrite_i = v.wb_we; MEMWB_RDaddr_i = v.wb_rd; MEMWB_data_i = v.wb_data;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(v.e_vld));
    checkOutput($sformatf("vec%0d.data1", i), data1_o, v.e_d1);
    checkOutput($sformatf("vec%0d.data2", i), data2_o, v.e_d2);
    checkOutput($sformatf("vec%0d.rs2data", i), RS2data_o, v.e_rs2d);
    checkOutput($sformatf("vec%0d.aluctrl", i), 32'(ALUCtrl_o), 32'(v.e_ctrl));
    checkOutput($sformatf("vec%0d.rd", i), 32'(RDaddr_o), 32'(v.e_rd));
    checkOutput($sformatf("vec%0d.ctrlbits", i),
                32'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}),
                32'({v.e_rw, v.e_mtr, v.e_mr, v.e_mw}));
  endtask

  task automatic checkBubble(input string tag);
    checkOutput({tag, ".valid"}, 32'(valid_o), 32'd0);
    checkOutput({tag, ".ctrlbits"}, 32'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}), 32'd0);
    checkOutput({tag, ".aluctrl"}, 32'(ALUCtrl_o), 32'd0);
    checkOutput({tag, ".rd"}, 32'(RDaddr_o), 32'd0);
  endtask

  initial begin
    vec_t lw, lw0, use1, use2, ld;
    int exp_cnt;

    vecs[0] = '{default:0, rs1:5'd1, rs2:5'd2, rd:5'd4, d1:32'd5, d2:32'd9, imm:32'hFFFF_FFFC,
                alu_src:1'b1, ctrl:3'd3, rw:1'b1, vld:1'b1,
                e_vld:1'b1, e_d1:32'd5, e_d2:32'hFFFF_FFFC, e_rs2d:32'd9, e_ctrl:3'd3,
                e_rd:5'd4, e_rw:1'b1};
    vecs[1] = '{default:0, rs1:5'd7, rs2:5'd8, rd:5'd9, d1:32'h11, d2:32'h22, ctrl:3'd2,
                rw:1'b1, vld:1'b1, ex_we:1'b1, ex_rd:5'd7, ex_data:32'hAA,
                wb_we:1'b1, wb_rd:5'd7, wb_data:32'hBB,
                e_vld:1'b1, e_d1:32'hAA, e_d2:32'h22, e_rs2d:32'h22, e_ctrl:3'd2,
                e_rd:5'd9, e_rw:1'b1};
    vecs[2] = vecs[1];
    vecs[2].ex_we = 1'b0;
    vecs[2].e_d1 = 32'hBB;
    vecs[3] = '{default:0, rs1:5'd0, rs2:5'd8, rd:5'd9, d1:32'h33, d2:32'h22, ctrl:3'd1,
                rw:1'b1, vld:1'b1, ex_we:1'b1, ex_rd:5'd0, ex_data:32'hAA,
                wb_we:1'b1, wb_rd:5'd0, wb_data:32'hBB,
                e_vld:1'b1, e_d1:32'h33, e_d2:32'h22, e_rs2d:32'h22, e_ctrl:3'd1,
                e_rd:5'd9, e_rw:1'b1};
    vecs[4] = '{default:0, rs1:5'd1, rs2:5'd5, rd:5'd6, d1:32'd1, d2:32'h44, ctrl:3'd4,
                rw:1'b1, vld:1'b1, ex_we:1'b1, ex_rd:5'd5, ex_data:32'h55,
                wb_we:1'b1, wb_rd:5'd5, wb_data:32'h66,
                e_vld:1'b1, e_d1:32'd1, e_d2:32'h55, e_rs2d:32'h55, e_ctrl:3'd4,
                e_rd:5'd6, e_rw:1'b1};
    vecs[5] = vecs[4];
    vecs[5].alu_src = 1'b1;
    vecs[5].imm = 32'h100;
    vecs[5].ex_rd = 5'd6;
    vecs[5].e_d2 = 32'h100;
    vecs[5].e_rs2d = 32'h66;
    vecs[6] = '{default:0, rs1:5'd2, rs2:5'd3, rd:5'd0, d1:32'h1000, d2:32'hDEAD, imm:32'd8,
                alu_src:1'b1, mw:1'b1, vld:1'b1,
                e_vld:1'b1, e_d1:32'h1000, e_d2:32'd8, e_rs2d:32'hDEAD, e_mw:1'b1};
    vecs[7] = '{default:0, rs1:5'd4, rs2:5'd5, rd:5'd7, d1:32'h77, d2:32'h88,
                rw:1'b1, mtr:1'b1, mr:1'b1, mw:1'b1, vld:1'b0,
                e_vld:1'b0, e_d1:32'h77, e_d2:32'h88, e_rs2d:32'h88, e_rd:5'd7};
    vecs[8] = '{default:0, rs1:5'd1, rs2:5'd0, rd:5'd3, d1:32'd200, imm:32'd4, alu_src:1'b1,
                rw:1'b1, mtr:1'b1, mr:1'b1, vld:1'b1,
                e_vld:1'b1, e_d1:32'd200, e_d2:32'd4, e_rs2d:32'd0, e_rd:5'd3,
                e_rw:1'b1, e_mtr:1'b1, e_mr:1'b1};
    vecs[9] = '{default:0, rs1:5'd1, rs2:5'd2, rd:5'd10, d1:32'd7, d2:32'd8, ctrl:3'd6,
                rw:1'b1, vld:1'b1,
                e_vld:1'b1, e_d1:32'd7, e_d2:32'd8, e_rs2d:32'd8, e_ctrl:3'd6,
                e_rd:5'd10, e_rw:1'b1};

    lw   = '{default:0, rs1:5'd1, rd:5'd3, d1:32'h40, imm:32'd4, alu_src:1'b1,
             rw:1'b1, mtr:1'b1, mr:1'b1, vld:1'b1};
    lw0  = lw;
    lw0.rd = 5'd0;
    use1 = '{default:0, rs1:5'd3, rs2:5'd2, rd:5'd5, d1:32'd9, d2:32'd9, ctrl:3'd2,
             rw:1'b1, vld:1'b1};
    use2 = '{default:0, rs1:5'd1, rs2:5'd3, rd:5'd6, imm:32'd1, alu_src:1'b1,
             rw:1'b1, vld:1'b1};
    ld   = vecs[0];

    // Reset state
    tick();
    tick();
    checkBubble("reset");
    checkOutput("reset.data1", data1_o, 32'd0);
    checkOutput("reset.data2", data2_o, 32'd0);
    checkOutput("reset.rs2data", RS2data_o, 32'd0);
    checkOutput("reset.count", 32'(bubble_cnt_o), 32'd0);
    checkOutput("reset.hazard", 32'(hazard_o), 32'd0);
    rst_i = 1'b0;

    // Table-driven load and forwarding
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkVector(i, vecs[i]);
    end

    // Load-use hazard on rs1
    applyStimulus(lw);
    tick();
    checkOutput("lu.memread", 32'(MemRead_o), 32'd1);
    applyStimulus(use1);
    #1;
    checkOutput("lu.hazard_rs1", 32'(hazard_o), 32'd1);
    tick();
    checkBubble("lu.bubble");
    checkOutput("lu.count", 32'(bubble_cnt_o), 32'd1);
    checkOutput("lu.hazard_after", 32'(hazard_o), 32'd0);
    tick();
    checkOutput("lu.reissue_valid", 32'(valid_o), 32'd1);
    checkOutput("lu.reissue_rd", 32'(RDaddr_o), 32'd5);

    // Load-use on rs2 with ALUSrc set still stalls
    applyStimulus(lw);
    tick();
    applyStimulus(use2);
    #1;
    checkOutput("lu.hazard_rs2", 32'(hazard_o), 32'd1);
    tick();
    checkOutput("lu.count2", 32'(bubble_cnt_o), 32'd2);

    // No hazard for a load to x0 or for an empty ID slot
    applyStimulus(lw0);
    tick();
    use1.rs1 = 5'd0;
    applyStimulus(use1);
    #1;
    checkOutput("lu.hazard_x0", 32'(hazard_o), 32'd0);
    applyStimulus(lw);
    tick();
    use1.rs1 = 5'd3;
    use1.vld = 1'b0;
    applyStimulus(use1);
    #1;
    checkOutput("lu.hazard_novalid", 32'(hazard_o), 32'd0);
    tick();
    checkOutput("lu.count_novalid", 32'(bubble_cnt_o), 32'd2);
    use1.vld = 1'b1;

    // Stall beats flush beats hazard
    applyStimulus(lw);
    tick();
    applyStimulus(use1);
    stall_i = 1'b1;
    flush_i = 1'b1;
    #1;
    checkOutput("prio.hazard", 32'(hazard_o), 32'd1);
    tick();
    checkOutput("prio.stall_valid", 32'(valid_o), 32'd1);
    checkOutput("prio.stall_memread", 32'(MemRead_o), 32'd1);
    checkOutput("prio.stall_rd", 32'(RDaddr_o), 32'd3);
    checkOutput("prio.stall_count", 32'(bubble_cnt_o), 32'd2);
    stall_i = 1'b0;
    tick();
    checkBubble("prio.flush");
    checkOutput("prio.flush_count", 32'(bubble_cnt_o), 32'd2);
    flush_i = 1'b0;

    // Asynchronous reset mid-cycle
    applyStimulus(ld);
    tick();
    checkOutput("arst.pre_valid", 32'(valid_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    checkBubble("arst");
    checkOutput("arst.data1", data1_o, 32'd0);
    checkOutput("arst.data2", data2_o, 32'd0);
    checkOutput("arst.rs2data", RS2data_o, 32'd0);
    checkOutput("arst.count", 32'(bubble_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Counter saturation on the narrow twin; the wide counter keeps counting
    exp_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(lw);
      tick();
      applyStimulus(use1);
      #1;
      tick();
      exp_cnt++;
      checkOutput($sformatf("sat.count_k%0d", k), 32'(bubble_cnt_o), 32'(exp_cnt));
      checkOutput($sformatf("sat.narrow_k%0d", k), 32'(s_cnt), (exp_cnt > 7) ? 32'd7 : 32'(exp_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
